lcd_frame_tx: RTL and testbench
===============================

// Module: lcd_frame_tx
// PURPOSE
//  Serialises one snapshot of the debug-display bus (lcd_a/lcd_b, register file, pc, instruction,
//  control flags) into an ASCII-hex byte stream with valid/ready handshake. Sits beside top as the
//  consuming end of its lcd_* outputs and feeds the host/UART link that repaints the LCD panel.
//  The display bus is sampled once per start; the frame always reflects that single cycle.
// PARAMETERS
//  NBITS_TOP    8      width of each register/pc field (multiple of 4)
//  NREGS_TOP    32     number of lcd_registrador entries
//  NBITS_LCD    64     width of lcd_a, lcd_b (multiple of 4)
//  NINSTR_BITS  32     width of lcd_instruction (multiple of 4)
//  SOF_BYTE     8'h02  frame start marker
//  EOF_BYTE     8'h0A  frame end marker
// PORTS
//  clk_2            in   1                  system clock, all logic on rising edge
//  reset            in   1                  synchronous, active-high
//  start            in   1                  1-cycle request: snapshot bus and send one frame
//  lcd_a, lcd_b     in   NBITS_LCD          display words
//  lcd_registrador  in   NBITS_TOP x NREGS_TOP  register file view, index 0..NREGS_TOP-1
//  lcd_pc           in   NBITS_TOP          program counter
//  lcd_instruction  in   NINSTR_BITS        current instruction
//  lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite  in 1 each  control flags
//  tx_data          out  8                  byte offered to sink
//  tx_valid         out  1                  tx_data valid
//  tx_ready         in   1                  sink accepts when tx_valid & tx_ready
//  busy             out  1                  frame in progress (snapshot held)
//  done             out  1                  1-cycle pulse after EOF accepted
// BEHAVIOUR
//  Reset: tx_valid=0, tx_data=0, busy=0, done=0, FSM=IDLE; frame in flight aborted, no EOF sent.
//  FSM: IDLE->SOF->A->B->REG->PC->INSTR->FLAGS->EOF->IDLE. Each non-IDLE state holds until its
//   current byte handshakes; nibble counter (and reg index in REG) advance on handshake only.
//  IDLE: start=1 -> capture all inputs into snapshot regs, busy=1, next cycle tx_valid=1 with
//   tx_data=SOF_BYTE (start-to-first-byte latency 1 cycle). start while busy=1 is ignored.
//  Byte order: SOF; lcd_a NBITS_LCD/4 chars; lcd_b same; reg[0]..reg[NREGS_TOP-1], NBITS_TOP/4
//   chars each; pc NBITS_TOP/4 chars; instruction NINSTR_BITS/4 chars; one flags char; EOF.
//   Every field is MSB nibble first. Defaults: 1+16+16+64+2+8+1+1 = 109 bytes.
//  Flags char = hex of {MemWrite,Branch,MemtoReg,RegWrite} (MemWrite = bit 3).
//  Hex encoding: nibble n<10 -> 8'h30+n; n>=10 -> 8'h41+n-10 (uppercase only).
//  Handshake: tx_data/tx_valid registered; while tx_valid & !tx_ready, tx_data holds stable and
//   tx_valid stays 1. tx_valid never drops mid-frame. With tx_ready held 1: one byte per cycle,
//   no bubbles between fields or states.
//  End: cycle after EOF handshake: tx_valid=0, busy=0, done=1 for exactly one cycle. start in that
//   cycle is accepted (busy already 0); start in the EOF-handshake cycle itself is ignored.
//  Snapshot isolation: input changes while busy=1 never affect the current frame.
//  Reset mid-frame: next cycle all outputs at reset values; next start sends a full new frame.
// TESTING
//  1 Assert reset 2 cycles, tx_ready=1 -> tx_valid=0, busy=0, done=0, tx_data=0 throughout.
//  2 lcd_a=64'h1234567890ABCD5A, lcd_b=64'h5AFEDCBA09876543, reg[i]=i*17, pc=8'h12,
//    instr=32'h34567890, flags=4'b0000, tx_ready=1, start pulse -> 109 consecutive bytes:
//    02,"1234567890ABCD5A","5AFEDCBA09876543","001122..",... ,"12","34567890","0",0A; done 1 cycle later.
//  3 Same start, then change every input on the following cycle -> byte stream identical to test 2.
//  4 tx_ready random (~50%) -> same 109-byte sequence; tx_data never changes while valid&!ready.
//  5 reg[15]=8'hF0, flags MemWrite=1,MemtoReg=1 -> reg[15] chars "F0", flags char 'A' (8'h41).
//  6 start again at byte 40 -> ignored; reset at byte 50 -> tx_valid=0 next cycle, no EOF;
//    new start -> fresh frame beginning with 02, 109 bytes.

Source files
------------

// File: rtl/lcd_frame_tx_if.sv
// Byte-stream handshake between the LCD frame serialiser and its sink.
// Master drives data/valid, slave drives ready.
interface lcd_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/lcd_frame_tx.sv
// Snapshots the debug-display bus on start and streams it as one
// ASCII-hex frame (SOF, fields MSB nibble first, flags, EOF).
module lcd_frame_tx #(
  parameter int          NBITS_TOP   = 8,
  parameter int          NREGS_TOP   = 32,
  parameter int          NBITS_LCD   = 64,
  parameter int          NINSTR_BITS = 32,
  parameter logic [7:0]  SOF_BYTE    = 8'h02,
  parameter logic [7:0]  EOF_BYTE    = 8'h0A
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NBITS_LCD-1:0]   lcd_a,
  input  logic [NBITS_LCD-1:0]   lcd_b,
  input  logic [NBITS_TOP-1:0]   lcd_registrador [NREGS_TOP],
  input  logic [NBITS_TOP-1:0]   lcd_pc,
  input  logic [NINSTR_BITS-1:0] lcd_instruction,
  input  logic                   lcd_MemWrite,
  input  logic                   lcd_Branch,
  input  logic                   lcd_MemtoReg,
  input  logic                   lcd_RegWrite,
  lcd_frame_tx_if.master         tx,
  output logic                   busy,
  output logic                   done
);

  localparam int NL   = NBITS_LCD / 4;
  localparam int NR   = NBITS_TOP / 4;
  localparam int NI   = NINSTR_BITS / 4;
  localparam int NM0  = (NL > NR) ? NL : NR;
  localparam int NMAX = (NM0 > NI) ? NM0 : NI;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int RW   = (NREGS_TOP > 1) ? $clog2(NREGS_TOP) : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SOF   = 4'd1;
  localparam logic [3:0] S_A     = 4'd2;
  localparam logic [3:0] S_B     = 4'd3;
  localparam logic [3:0] S_REG   = 4'd4;
  localparam logic [3:0] S_PC    = 4'd5;
  localparam logic [3:0] S_INSTR = 4'd6;
  localparam logic [3:0] S_FLAGS = 4'd7;
  localparam logic [3:0] S_EOF   = 4'd8;

  logic [3:0]             st_q, st_d;
  logic [CW-1:0]          nib_q, nib_d;
  logic [RW-1:0]          reg_q, reg_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [NBITS_LCD-1:0]   a_q, a_d;
  logic [NBITS_LCD-1:0]   b_q, b_d;
  logic [NBITS_TOP-1:0]   regs_q [NREGS_TOP];
  logic [NBITS_TOP-1:0]   regs_d [NREGS_TOP];
  logic [NBITS_TOP-1:0]   pc_q, pc_d;
  logic [NINSTR_BITS-1:0] ins_q, ins_d;
  logic [3:0]             flg_q, flg_d;

  logic [3:0]             nx_st;
  logic [CW-1:0]          nx_nib;
  logic [RW-1:0]          nx_reg;
  logic [3:0]             nib_v;
  logic [7:0]             byte_v;
  int                     sh;

  function automatic logic [7:0] hex(input logic [3:0] n);
    hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Position of the byte that follows the one now on the bus.
  always_comb begin
    nx_st  = st_q;
    nx_nib = nib_q + 1'b1;
    nx_reg = reg_q;
    case (st_q)
      S_SOF: begin
        nx_st  = S_A;
        nx_nib = '0;
      end
      S_A: begin
        if (nib_q == CW'(NL - 1)) begin
          nx_st  = S_B;
          nx_nib = '0;
        end
      end
      S_B: begin
        if (nib_q == CW'(NL - 1)) begin
          nx_st  = S_REG;
          nx_nib = '0;
          nx_reg = '0;
        end
      end
      S_REG: begin
        if (nib_q == CW'(NR - 1)) begin
          nx_nib = '0;
          if (reg_q == RW'(NREGS_TOP - 1)) nx_st = S_PC;
          else nx_reg = reg_q + 1'b1;
        end
      end
      S_PC: begin
        if (nib_q == CW'(NR - 1)) begin
          nx_st  = S_INSTR;
          nx_nib = '0;
        end
      end
      S_INSTR: begin
        if (nib_q == CW'(NI - 1)) begin
          nx_st  = S_FLAGS;
          nx_nib = '0;
        end
      end
      S_FLAGS: begin
        nx_st  = S_EOF;
        nx_nib = '0;
      end
      default: begin
        nx_st  = S_IDLE;
        nx_nib = '0;
      end
    endcase
  end

  always_comb begin
    sh    = 0;
    nib_v = 4'h0;
    case (nx_st)
      S_A: begin
        sh    = 4 * (NL - 1 - int'(nx_nib));
        nib_v = 4'(a_q >> sh);
      end
      S_B: begin
        sh    = 4 * (NL - 1 - int'(nx_nib));
        nib_v = 4'(b_q >> sh);
      end
      S_REG: begin
        sh    = 4 * (NR - 1 - int'(nx_nib));
        nib_v = 4'(regs_q[nx_reg] >> sh);
      end
      S_PC: begin
        sh    = 4 * (NR - 1 - int'(nx_nib));
        nib_v = 4'(pc_q >> sh);
      end
      S_INSTR: begin
        sh    = 4 * (NI - 1 - int'(nx_nib));
        nib_v = 4'(ins_q >> sh);
      end
      S_FLAGS: nib_v = flg_q;
      default: nib_v = 4'h0;
    endcase
    byte_v = (nx_st == S_EOF) ? EOF_BYTE : hex(nib_v);
  end

  always_comb begin
    st_d       = st_q;
    nib_d      = nib_q;
    reg_d      = reg_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    regs_d     = regs_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    flg_d      = flg_q;
    if (st_q == S_IDLE) begin
      if (start) begin
        a_d        = lcd_a;
        b_d        = lcd_b;
        regs_d     = lcd_registrador;
        pc_d       = lcd_pc;
        ins_d      = lcd_instruction;
        flg_d      = {lcd_MemWrite, lcd_Branch,
                      lcd_MemtoReg, lcd_RegWrite};
        st_d       = S_SOF;
        nib_d      = '0;
        reg_d      = '0;
        tx_data_d  = SOF_BYTE;
        tx_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
    end else if (tx_valid_q && tx.tx_ready) begin
      if (st_q == S_EOF) begin
        st_d       = S_IDLE;
        nib_d      = '0;
        reg_d      = '0;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end else begin
        st_d      = nx_st;
        nib_d     = nx_nib;
        reg_d     = nx_reg;
        tx_data_d = byte_v;
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      st_q       <= S_IDLE;
      nib_q      <= '0;
      reg_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      nib_q      <= nib_d;
      reg_q      <= reg_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Snapshot is only read while busy, so it needs no reset.
  always_ff @(posedge clk_2) begin
    a_q    <= a_d;
    b_q    <= b_d;
    regs_q <= regs_d;
    pc_q   <= pc_d;
    ins_q  <= ins_d;
    flg_q  <= flg_d;
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_lcd_frame_tx.sv
// Scoreboard bench for lcd_frame_tx: expected frames are built from
// the input snapshot as hex text and checked byte by byte.
module tb_lcd_frame_tx;
  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] lcd_a = '0;
  logic [63:0] lcd_b = '0;
  logic [7:0]  regs [32];
  logic [7:0]  lcd_pc = '0;
  logic [31:0] lcd_instruction = '0;
  logic        mw = 1'b0, br = 1'b0, mr = 1'b0, rw = 1'b0;
  logic        busy, done;

  lcd_frame_tx_if tx_if ();

  lcd_frame_tx dut (
    .clk_2           (clk_2),
    .reset           (reset),
    .start           (start),
    .lcd_a           (lcd_a),
    .lcd_b           (lcd_b),
    .lcd_registrador (regs),
    .lcd_pc          (lcd_pc),
    .lcd_instruction (lcd_instruction),
    .lcd_MemWrite    (mw),
    .lcd_Branch      (br),
    .lcd_MemtoReg    (mr),
    .lcd_RegWrite    (rw),
    .tx              (tx_if),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk_2 = ~clk_2;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  rec [$];
  int          byte_cnt = 0;
  bit          rnd_ready = 1'b0;
  bit          exp_done = 1'b0;
  bit          hold_v = 1'b0;
  logic [7:0]  hold_d = '0;
  bit          r_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: SOF, uppercase hex text of every field, EOF.
  task automatic push_frame();
    string      s;
    logic [3:0] f;
    f = {mw, br, mr, rw};
    s = $sformatf("%h%h", lcd_a, lcd_b);
    for (int i = 0; i < 32; i++) s = {s, $sformatf("%h", regs[i])};
    s = {s, $sformatf("%h%h%h", lcd_pc, lcd_instruction, f)};
    s = s.toupper();
    exp_q.push_back(8'h02);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0A);
  endtask

  task automatic set_known();
    lcd_a = 64'h1234567890ABCD5A;
    lcd_b = 64'h5AFEDCBA09876543;
    for (int i = 0; i < 32; i++) regs[i] = 8'(i * 17);
    lcd_pc = 8'h12;
    lcd_instruction = 32'h34567890;
    {mw, br, mr, rw} = 4'b0000;
  endtask

  task automatic rand_inputs();
    lcd_a = {$urandom, $urandom};
    lcd_b = {$urandom, $urandom};
    for (int i = 0; i < 32; i++) regs[i] = 8'($urandom);
    lcd_pc = 8'($urandom);
    lcd_instruction = $urandom;
    {mw, br, mr, rw} = 4'($urandom);
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic send_frame();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(n), 0);
    rec.delete();
    byte_cnt = 0;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sof_valid", 32'(tx_if.tx_valid), 1);
    chk("sof_data", 32'(tx_if.tx_data), 32'h02);
  endtask

  task automatic wait_frame();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("frame_timeout", 32'(n), 0);
    tick();
    chk("frame_len", 32'(rec.size()), 109);
  endtask

  task automatic wait_bytes(input int k);
    int n = 0;
    while (byte_cnt < k && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("byte_timeout", 32'(byte_cnt), 32'(k));
  endtask

  function automatic logic [7:0] rec_at(input int i);
    rec_at = (i < rec.size()) ? rec[i] : 8'hxx;
  endfunction

  initial begin
    forever begin
      @(posedge clk_2);
      #1;
      tx_if.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshakes are judged on the falling edge, mid-cycle.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_2);
      if (r_prev) begin
        chk("rst_valid", 32'(tx_if.tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(tx_if.tx_data), 0);
      end else if (!reset) begin
        if (exp_done) begin
          chk("done_pulse", 32'(done), 1);
          chk("done_valid", 32'(tx_if.tx_valid), 0);
          chk("done_busy", 32'(busy), 0);
          exp_done = 1'b0;
        end else if (done) begin
          chk("stray_done", 32'(done), 0);
        end
        if (hold_v) begin
          chk("hold_valid", 32'(tx_if.tx_valid), 1);
          chk("hold_data", 32'(tx_if.tx_data), 32'(hold_d));
        end
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          rec.push_back(tx_if.tx_data);
          byte_cnt++;
          if (exp_q.size() == 0) begin
            chk("extra_byte", 32'(tx_if.tx_data), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(tx_if.tx_data), 32'(e));
            if (e == 8'h0A) exp_done = 1'b1;
          end
        end
      end
      if (reset) exp_done = 1'b0;
      hold_v = !reset && tx_if.tx_valid && !tx_if.tx_ready;
      hold_d = tx_if.tx_data;
      r_prev = reset;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (2) tick();
    chk("reset_valid", 32'(tx_if.tx_valid), 0);
    chk("reset_data", 32'(tx_if.tx_data), 0);
    reset = 1'b0;
    tick();

    set_known();
    send_frame();
    wait_frame();
    chk("t2_a0", 32'(rec_at(1)), 32'h31);
    chk("t2_a15", 32'(rec_at(16)), 32'h41);
    chk("t2_b0", 32'(rec_at(17)), 32'h35);
    chk("t2_r0", 32'(rec_at(33)), 32'h30);
    chk("t2_r1", 32'(rec_at(35)), 32'h31);
    chk("t2_r15", 32'(rec_at(63)), 32'h46);
    chk("t2_pc", 32'(rec_at(97)), 32'h31);
    chk("t2_ins", 32'(rec_at(99)), 32'h33);
    chk("t2_flg", 32'(rec_at(107)), 32'h30);
    chk("t2_eof", 32'(rec_at(108)), 32'h0A);

    set_known();
    send_frame();
    rand_inputs();
    wait_frame();

    rnd_ready = 1'b1;
    set_known();
    send_frame();
    wait_frame();
    rnd_ready = 1'b0;

    set_known();
    regs[15] = 8'hF0;
    {mw, br, mr, rw} = 4'b1010;
    send_frame();
    wait_frame();
    chk("t5_r15h", 32'(rec_at(63)), 32'h46);
    chk("t5_r15l", 32'(rec_at(64)), 32'h30);
    chk("t5_flg", 32'(rec_at(107)), 32'h41);

    for (int k = 0; k < 4; k++) begin
      rnd_ready = 1'($urandom_range(0, 1));
      rand_inputs();
      send_frame();
      repeat ($urandom_range(1, 20)) tick();
      rand_inputs();
      wait_frame();
    end

    rnd_ready = 1'b1;
    rand_inputs();
    send_frame();
    wait_bytes(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(50);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(tx_if.tx_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    tick();
    rand_inputs();
    send_frame();
    wait_frame();
    chk("t6_sof", 32'(rec_at(0)), 32'h02);
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
